tv_checker: RTL

Parametrised, synthesizable self-checking vector engine for the hack_emu benches and FPGA bring-up. It replaces hand-written per-DUT vector loops.
- Holds DEPTH vectors of {stimulus, expected response, compare mask}.
- Drives stimulus to a DUT, waits SETTLE cycles, then compares the masked response.
- Counts errors and reports pass/fail.
- Generalises the fixed-width, "stop on X" vector loop: configurable widths and depth, an explicit vector count, per-bit masking, and a restartable run.

---
 rtl/tvc_pkg.sv | 28 ++
 rtl/tv_checker_vec_ram.sv | 24 ++
 rtl/tv_checker.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/tvc_pkg.sv
// tv_checker shared types: FSM state encoding and ld_data field offsets.
// Field layout of a vector word is {stim, exp, mask}, mask in the LSBs.
package tvc_pkg;

  typedef enum logic [2:0] {
    TVC_IDLE,
    TVC_FETCH,
    TVC_SETTLE,
    TVC_CHECK,
    TVC_DONE
  } tvc_state_e;

  // LSB position of the mask field inside a vector word
  function automatic int tvc_mask_lsb();
    return 0;
  endfunction

  // LSB position of the expected-response field
  function automatic int tvc_exp_lsb(input int resp_w);
    return resp_w;
  endfunction

  // LSB position of the stimulus field
  function automatic int tvc_stim_lsb(input int resp_w);
    return 2 * resp_w;
  endfunction

endpackage

// File: rtl/tv_checker_vec_ram.sv
// Vector store: DEPTH x VW, one write port, one synchronous read port.
// A same-cycle write to the read address is forwarded (write-first).
module tvc_vec_ram #(
  parameter  int DEPTH = 128,
  parameter  int VW    = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [VW-1:0] wd_i,
  input  logic [AW-1:0] ra_i,
  output logic [VW-1:0] rd_o
);

  logic [VW-1:0] mem_q [DEPTH];

  // write port plus registered read with write-first forwarding
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wa_i] <= wd_i;
    rd_o <= (we_i && (wa_i == ra_i)) ? wd_i : mem_q[ra_i];
  end

endmodule

// File: rtl/tv_checker.sv
// tv_checker: stored-vector stimulus/compare engine with masked checking.
// Optional TVC_STOP_ON_ERR_EN: end the run at the first mismatch.
module tv_checker #(
  parameter  int STIM_W = 32,
  parameter  int RESP_W = 64,
  parameter  int DEPTH  = 128,
  parameter  int SETTLE = 1,
  parameter  int CNT_W  = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int VW     = STIM_W + 2 * RESP_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [VW-1:0]     ld_data,
  input  logic [AW:0]       num_vec,
  input  logic              start,
  output logic [STIM_W-1:0] stim,
  output logic              stim_valid,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              first_err_valid,
  output logic [AW-1:0]     first_err_idx,
  output logic [AW-1:0]     vec_idx
);
  import tvc_pkg::*;

  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam int STIM_LSB = tvc_stim_lsb(RESP_W);
  localparam int EXP_LSB  = tvc_exp_lsb(RESP_W);
  localparam int MASK_LSB = tvc_mask_lsb();

  tvc_state_e        state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW:0]       nv_q, nv_d, nv_clamp;
  logic [SW-1:0]     set_q, set_d;
  logic [STIM_W-1:0] stim_q, stim_d;
  logic [RESP_W-1:0] exp_q, exp_d;
  logic [RESP_W-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              fev_q, fev_d;
  logic [AW-1:0]     fei_q, fei_d;
  logic [VW-1:0]     rd_data;
  logic              idle_like;
  logic              wr_en;
  logic              mismatch;
  logic              last;
  logic              stop_err;

  assign idle_like = (state_q == TVC_IDLE) || (state_q == TVC_DONE);
  assign wr_en     = idle_like && ld_en;
  assign nv_clamp  = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
  assign mismatch  = |((resp ^ exp_q) & mask_q);
  assign last      = ({1'b0, idx_q} == (nv_q - 1'b1));

`ifdef TVC_STOP_ON_ERR_EN
  assign stop_err = mismatch;
`else
  assign stop_err = 1'b0;
`endif

  // read address tracks the next index so data is ready during FETCH
  tvc_vec_ram #(
    .DEPTH (DEPTH),
    .VW    (VW)
  ) u_ram (
    .clk_i (clock),
    .we_i  (wr_en),
    .wa_i  (ld_addr),
    .wd_i  (ld_data),
    .ra_i  (idx_d),
    .rd_o  (rd_data)
  );

  // state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= TVC_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TVC_IDLE, TVC_DONE: begin
        if (start) state_d = (nv_clamp == '0) ? TVC_DONE : TVC_FETCH;
      end
      TVC_FETCH:  state_d = TVC_SETTLE;
      TVC_SETTLE: if (set_q == SW'(1)) state_d = TVC_CHECK;
      TVC_CHECK:  state_d = (last || stop_err) ? TVC_DONE : TVC_FETCH;
      default:    state_d = TVC_IDLE;
    endcase
  end

  // outputs decoded from state and datapath registers
  always_comb begin
    busy       = (state_q == TVC_FETCH) || (state_q == TVC_SETTLE) ||
                 (state_q == TVC_CHECK);
    stim_valid = (state_q == TVC_SETTLE) || (state_q == TVC_CHECK);
    done       = (state_q == TVC_DONE);
    pass       = done && (err_q == '0);
  end

  // datapath next values: run setup, vector capture, compare bookkeeping
  always_comb begin
    idx_d  = idx_q;
    nv_d   = nv_q;
    set_d  = set_q;
    stim_d = stim_q;
    exp_d  = exp_q;
    mask_d = mask_q;
    err_d  = err_q;
    fev_d  = fev_q;
    fei_d  = fei_q;
    unique case (state_q)
      TVC_IDLE, TVC_DONE: begin
        if (start) begin
          nv_d  = nv_clamp;
          idx_d = '0;
          err_d = '0;
          fev_d = 1'b0;
          fei_d = '0;
        end
      end
      TVC_FETCH: begin
        stim_d = rd_data[STIM_LSB +: STIM_W];
        exp_d  = rd_data[EXP_LSB +: RESP_W];
        mask_d = rd_data[MASK_LSB +: RESP_W];
        set_d  = SW'(SETTLE);
      end
      TVC_SETTLE: begin
        if (set_q != SW'(1)) set_d = set_q - 1'b1;
      end
      TVC_CHECK: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          if (!fev_q) begin
            fev_d = 1'b1;
            fei_d = idx_q;
          end
        end
        if (!last && !stop_err) idx_d = idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  // datapath registers, all cleared by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q  <= '0;
      nv_q   <= '0;
      set_q  <= '0;
      stim_q <= '0;
      exp_q  <= '0;
      mask_q <= '0;
      err_q  <= '0;
      fev_q  <= 1'b0;
      fei_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      nv_q   <= nv_d;
      set_q  <= set_d;
      stim_q <= stim_d;
      exp_q  <= exp_d;
      mask_q <= mask_d;
      err_q  <= err_d;
      fev_q  <= fev_d;
      fei_q  <= fei_d;
    end
  end

  assign stim            = stim_q;
  assign err_cnt         = err_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;
  assign vec_idx         = idx_q;

endmodule
